// File: rtl/mul8x8_rr_arbiter_if.sv
// Bundle of requester, response and multiplier-core signals for mul8x8_rr_arbiter.
// The arbiter connects through the slave modport.
// The master modport is the view seen by requesters and the multiplier core.
// When MUL_CHECK_EN is defined, the bundle also carries resp_err.
interface mul8x8_rr_arbiter_if #(
  parameter int NREQ = 4
);
  logic [NREQ-1:0]   req;
  logic [8*NREQ-1:0] req_a;
  logic [8*NREQ-1:0] req_b;
  logic [NREQ-1:0]   gnt;
  logic              resp_valid;
  logic [2:0]        resp_id;
  logic [15:0]       resp_data;
  logic              mul_st;
  logic [7:0]        mul_a;
  logic [7:0]        mul_b;
  logic [15:0]       mul_answer;
`ifdef MUL_CHECK_EN
  logic              resp_err;
`endif

  modport slave (
    input  req, req_a, req_b, mul_answer,
    output gnt, resp_valid, resp_id, resp_data, mul_st, mul_a, mul_b
`ifdef MUL_CHECK_EN
    , output resp_err
`endif
  );

  modport master (
    output req, req_a, req_b, mul_answer,
    input  gnt, resp_valid, resp_id, resp_data, mul_st, mul_a, mul_b
`ifdef MUL_CHECK_EN
    , input resp_err
`endif
  );
endinterface

// File: rtl/mul8x8_rr_arbiter.sv
// mul8x8_rr_arbiter: shares one fixed-latency sequential 8x8 multiplier core
// between NREQ requesters.
// Arbitration is round-robin. The winning requester's operands are held on the
// core for the whole operation, and the product is returned tagged with the
// winner's index.
// Optional feature MUL_CHECK_EN: adds resp_err, which flags a core answer that
// differs from an internally computed product.
module mul8x8_rr_arbiter #(
  parameter int NREQ    = 4,
  parameter int MUL_LAT = 10,
  parameter int ST_CYC  = 1
) (
  input logic clk,
  input logic rst,
  mul8x8_rr_arbiter_if.slave bus
);
  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = $clog2(MUL_LAT + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   ptr_q, ptr_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2:0]      id_q, id_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic            mul_st_q, mul_st_d;
  logic [7:0]      mul_a_q, mul_a_d;
  logic [7:0]      mul_b_q, mul_b_d;
  logic            resp_valid_q, resp_valid_d;
  logic [2:0]      resp_id_q, resp_id_d;
  logic [15:0]     resp_data_q, resp_data_d;

  logic [7:0]      op_a [NREQ];
  logic [7:0]      op_b [NREQ];
  logic [PW-1:0]   sel;
  logic            any_req;
  logic            last_cyc;

  // Unpack the per-requester operand buses.
  generate
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_ops
      assign op_a[gi] = bus.req_a[8*gi +: 8];
      assign op_b[gi] = bus.req_b[8*gi +: 8];
    end
  endgenerate

  assign last_cyc = (cnt_q == CW'(MUL_LAT - 1));

  // Pick the first active request at or above the pointer, wrapping past NREQ-1.
  // The scan runs downward so that the lowest rotated offset is assigned last.
  always_comb begin
    int j;
    j       = 0;
    sel     = '0;
    any_req = |bus.req;
    for (int k = NREQ - 1; k >= 0; k--) begin
      j = int'(ptr_q) + k;
      if (j >= NREQ) j = j - NREQ;
      if (bus.req[PW'(j)]) sel = PW'(j);
    end
  end

`ifdef MUL_CHECK_EN
  logic        resp_err_q, resp_err_d;
  logic [15:0] chk_prod;
  assign chk_prod     = 16'(mul_a_q) * 16'(mul_b_q);
  assign bus.resp_err = resp_err_q;
`endif

  // State register; rst low returns the FSM to IDLE and aborts any operation.
  always_ff @(posedge clk) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (any_req) state_d = RUN;
      RUN:     if (last_cyc) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output and datapath next values. The gnt and resp_valid strobes default to 0.
  always_comb begin
    ptr_d        = ptr_q;
    cnt_d        = cnt_q;
    id_d         = id_q;
    gnt_d        = '0;
    mul_st_d     = mul_st_q;
    mul_a_d      = mul_a_q;
    mul_b_d      = mul_b_q;
    resp_valid_d = 1'b0;
    resp_id_d    = resp_id_q;
    resp_data_d  = resp_data_q;
`ifdef MUL_CHECK_EN
    resp_err_d   = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (any_req) begin
          gnt_d    = NREQ'(1) << sel;
          mul_a_d  = op_a[sel];
          mul_b_d  = op_b[sel];
          mul_st_d = 1'b1;
          id_d     = 3'(sel);
          cnt_d    = '0;
          ptr_d    = (int'(sel) == NREQ - 1) ? '0 : sel + PW'(1);
        end
      end
      RUN: begin
        cnt_d    = cnt_q + CW'(1);
        // mul_st has already been high for cnt_q+1 cycles.
        mul_st_d = ({1'b0, cnt_q} + (CW+1)'(1)) < (CW+1)'(ST_CYC);
        if (last_cyc) begin
          resp_data_d  = bus.mul_answer;
          resp_id_d    = id_q;
          resp_valid_d = 1'b1;
`ifdef MUL_CHECK_EN
          resp_err_d   = (chk_prod != bus.mul_answer);
`endif
        end
      end
      default: ;
    endcase
  end

  // Datapath and output registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      ptr_q        <= '0;
      cnt_q        <= '0;
      id_q         <= '0;
      gnt_q        <= '0;
      mul_st_q     <= 1'b0;
      mul_a_q      <= '0;
      mul_b_q      <= '0;
      resp_valid_q <= 1'b0;
      resp_id_q    <= '0;
      resp_data_q  <= '0;
`ifdef MUL_CHECK_EN
      resp_err_q   <= 1'b0;
`endif
    end else begin
      ptr_q        <= ptr_d;
      cnt_q        <= cnt_d;
      id_q         <= id_d;
      gnt_q        <= gnt_d;
      mul_st_q     <= mul_st_d;
      mul_a_q      <= mul_a_d;
      mul_b_q      <= mul_b_d;
      resp_valid_q <= resp_valid_d;
      resp_id_q    <= resp_id_d;
      resp_data_q  <= resp_data_d;
`ifdef MUL_CHECK_EN
      resp_err_q   <= resp_err_d;
`endif
    end
  end

  assign bus.gnt        = gnt_q;
  assign bus.mul_st     = mul_st_q;
  assign bus.mul_a      = mul_a_q;
  assign bus.mul_b      = mul_b_q;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_id    = resp_id_q;
  assign bus.resp_data  = resp_data_q;
endmodule

// File: tb/tb_mul8x8_rr_arbiter.sv
// Testbench for mul8x8_rr_arbiter, including a behavioural model of the
// fixed-latency multiplier core.
// The core model drives 16'hDEAD until its answer is valid. A programmable bias
// lets it return a wrong product on purpose.
module tb_mul8x8_rr_arbiter;
  localparam int NREQ    = 4;
  localparam int MUL_LAT = 10;
  localparam int ST_CYC  = 1;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mul8x8_rr_arbiter_if #(.NREQ(NREQ)) bus ();

  mul8x8_rr_arbiter #(.NREQ(NREQ), .MUL_LAT(MUL_LAT), .ST_CYC(ST_CYC)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // Core model: the first edge that sees mul_st high latches the operands.
  // The answer is valid from the edge after MUL_LAT-1 counted edges onward.
  int          core_cnt  = 0;
  logic        st_prev   = 1'b0;
  logic [7:0]  ca = 8'h00, cb = 8'h00;
  logic [15:0] core_bias = 16'h0000;

  always @(posedge clk) begin
    st_prev <= bus.mul_st;
    if (bus.mul_st && !st_prev) begin
      core_cnt <= 1;
      ca       <= bus.mul_a;
      cb       <= bus.mul_b;
    end else if (core_cnt != 0 && core_cnt < MUL_LAT) begin
      core_cnt <= core_cnt + 1;
    end
  end
  assign bus.mul_answer = (core_cnt >= MUL_LAT - 1) ? (16'(ca) * 16'(cb) + core_bias) : 16'hDEAD;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ops(input int i, input logic [7:0] a, input logic [7:0] b);
    bus.req_a[8*i +: 8] = a;
    bus.req_b[8*i +: 8] = b;
  endtask

  // Wait a bounded number of cycles for a grant; g stays 0 if none arrives.
  task automatic wait_gnt(output logic [NREQ-1:0] g, output int at);
    bit done;
    done = 0;
    g    = '0;
    at   = -1;
    for (int n = 0; n < 40 && !done; n++) begin
      tick();
      if (bus.gnt != '0) begin
        g    = bus.gnt;
        at   = cyc;
        done = 1;
        $display("gnt  cyc=%0d gnt=%b", cyc, g);
      end
    end
  endtask

  // Wait a bounded number of cycles for a result; seen stays 0 if none arrives.
  task automatic wait_resp(output bit seen, output logic [15:0] d, output logic [2:0] id,
                           output logic e, output int at);
    seen = 0;
    d    = '0;
    id   = '0;
    e    = 1'b0;
    at   = -1;
    for (int n = 0; n < 40 && !seen; n++) begin
      tick();
      if (bus.resp_valid) begin
        seen = 1;
        d    = bus.resp_data;
        id   = bus.resp_id;
`ifdef MUL_CHECK_EN
        e    = bus.resp_err;
`endif
        at   = cyc;
        $display("resp cyc=%0d id=%0d data=%h err=%b", cyc, id, d, e);
      end
    end
  endtask

  logic [NREQ-1:0] g;
  logic [15:0]     d;
  logic [2:0]      id;
  logic            e;
  int              at, t0, tprev;
  bit              seen;

  task automatic test_reset();
    rst      = 1'b0;
    bus.req  = 4'b1111;
    for (int i = 0; i < NREQ; i++) set_ops(i, 8'h01, 8'h01);
    for (int n = 0; n < 3; n++) begin
      tick();
      total++;
      if ({bus.gnt, bus.mul_st, bus.resp_valid} !== 6'b0) begin
        bad++;
        $display("FAIL reset_quiet[%0d]: gnt=%b mul_st=%b resp_valid=%b, want all 0",
                 n, bus.gnt, bus.mul_st, bus.resp_valid);
      end
    end
    total++;
    if ({bus.resp_data, bus.resp_id, bus.mul_a, bus.mul_b} !== 35'b0) begin
      bad++;
      $display("FAIL reset_regs: data=%h id=%0d a=%h b=%h, want 0", bus.resp_data, bus.resp_id,
               bus.mul_a, bus.mul_b);
    end
    rst = 1'b1;
    wait_gnt(g, at);
    total++;
    if (g !== 4'b0001) begin
      bad++;
      $display("FAIL reset_first_gnt: got %b want 0001", g);
    end
    bus.req = '0;
    wait_resp(seen, d, id, e, at);
  endtask

  task automatic test_single();
    set_ops(0, 8'h12, 8'h13);
    bus.req = 4'b0001;
    wait_gnt(g, t0);
    bus.req = '0;
    total++;
    if (g !== 4'b0001 || bus.mul_st !== 1'b1 || bus.mul_a !== 8'h12 || bus.mul_b !== 8'h13) begin
      bad++;
      $display("FAIL single_grant: gnt=%b st=%b a=%h b=%h, want 0001 1 12 13", g, bus.mul_st,
               bus.mul_a, bus.mul_b);
    end
    tick();
    total++;
    if (bus.mul_st !== 1'b0 || bus.gnt !== 4'b0000) begin
      bad++;
      $display("FAIL single_st_pulse: st=%b gnt=%b, want 0 0000", bus.mul_st, bus.gnt);
    end
    wait_resp(seen, d, id, e, at);
    total++;
    if (!seen || d !== 16'h0156 || id !== 3'd0 || at - t0 != MUL_LAT) begin
      bad++;
      $display("FAIL single_resp: seen=%0d data=%h id=%0d lat=%0d, want 1 0156 0 %0d", seen, d, id,
               at - t0, MUL_LAT);
    end
    tick();
    total++;
    if (bus.resp_valid !== 1'b0 || bus.resp_data !== 16'h0156) begin
      bad++;
      $display("FAIL single_hold: valid=%b data=%h, want 0 0156", bus.resp_valid, bus.resp_data);
    end
  endtask

  task automatic test_round_robin();
    logic [15:0] rr_exp [4];
    rr_exp = '{16'h0012, 16'h0024, 16'h0036, 16'h0048};
    rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    for (int i = 0; i < NREQ; i++) set_ops(i, 8'(i + 1), 8'h12);
    bus.req = 4'b1111;
    tprev = 0;
    for (int n = 0; n < 4; n++) begin
      wait_gnt(g, at);
      total++;
      if (g !== 4'(1 << n) || (n > 0 && at - tprev != MUL_LAT + 2)) begin
        bad++;
        $display("FAIL rr_gnt[%0d]: gnt=%b spacing=%0d, want %b %0d", n, g, at - tprev,
                 4'(1 << n), MUL_LAT + 2);
      end
      tprev = at;
      wait_resp(seen, d, id, e, at);
      total++;
      if (!seen || d !== rr_exp[n] || id !== 3'(n)) begin
        bad++;
        $display("FAIL rr_resp[%0d]: seen=%0d data=%h id=%0d, want 1 %h %0d", n, seen, d, id,
                 rr_exp[n], n);
      end
    end
    wait_gnt(g, at);
    bus.req = '0;
    total++;
    if (g !== 4'b0001 || at - tprev != MUL_LAT + 2) begin
      bad++;
      $display("FAIL rr_wrap_gnt: gnt=%b spacing=%0d, want 0001 %0d", g, at - tprev, MUL_LAT + 2);
    end
    wait_resp(seen, d, id, e, at);
    total++;
    if (!seen || d !== 16'h0012 || id !== 3'd0) begin
      bad++;
      $display("FAIL rr_wrap_resp: seen=%0d data=%h id=%0d, want 1 0012 0", seen, d, id);
    end
  endtask

  task automatic test_wrap_skip();
    set_ops(3, 8'h02, 8'h03);
    set_ops(1, 8'h05, 8'h07);
    bus.req = 4'b1000;
    wait_gnt(g, at);
    bus.req = 4'b1010;
    total++;
    if (g !== 4'b1000) begin
      bad++;
      $display("FAIL skip_gnt3: got %b want 1000", g);
    end
    wait_resp(seen, d, id, e, at);
    total++;
    if (!seen || d !== 16'h0006 || id !== 3'd3) begin
      bad++;
      $display("FAIL skip_resp3: seen=%0d data=%h id=%0d, want 1 0006 3", seen, d, id);
    end
    wait_gnt(g, at);
    bus.req = 4'b1000;
    total++;
    if (g !== 4'b0010) begin
      bad++;
      $display("FAIL skip_gnt1: got %b want 0010", g);
    end
    wait_resp(seen, d, id, e, at);
    total++;
    if (!seen || d !== 16'h0023 || id !== 3'd1) begin
      bad++;
      $display("FAIL skip_resp1: seen=%0d data=%h id=%0d, want 1 0023 1", seen, d, id);
    end
    wait_gnt(g, at);
    bus.req = '0;
    total++;
    if (g !== 4'b1000) begin
      bad++;
      $display("FAIL skip_gnt3b: got %b want 1000", g);
    end
    wait_resp(seen, d, id, e, at);
  endtask

  // A single requester holds req with new operands after each grant.
  task automatic test_edge_values();
    logic [7:0]  va [3];
    logic [7:0]  vb [3];
    logic [15:0] vp [3];
    va = '{8'hFF, 8'h23, 8'h00};
    vb = '{8'hFF, 8'h12, 8'h7F};
    vp = '{16'hFE01, 16'h0276, 16'h0000};
    set_ops(2, va[0], vb[0]);
    bus.req = 4'b0100;
    tprev = 0;
    for (int n = 0; n < 3; n++) begin
      wait_gnt(g, at);
      if (n < 2) set_ops(2, va[n + 1], vb[n + 1]);
      else bus.req = '0;
      total++;
      if (g !== 4'b0100 || (n > 0 && at - tprev != MUL_LAT + 2)) begin
        bad++;
        $display("FAIL edge_gnt[%0d]: gnt=%b spacing=%0d, want 0100 %0d", n, g, at - tprev,
                 MUL_LAT + 2);
      end
      tprev = at;
      wait_resp(seen, d, id, e, at);
      total++;
      if (!seen || d !== vp[n] || id !== 3'd2) begin
        bad++;
        $display("FAIL edge_resp[%0d]: seen=%0d data=%h id=%0d, want 1 %h 2", n, seen, d, id, vp[n]);
      end
    end
  endtask

  task automatic test_reset_mid_op();
    int vcount;
    set_ops(1, 8'h55, 8'h02);
    bus.req = 4'b0010;
    wait_gnt(g, at);
    bus.req = '0;
    total++;
    if (g !== 4'b0010) begin
      bad++;
      $display("FAIL midrst_gnt: got %b want 0010", g);
    end
    for (int n = 0; n < 4; n++) tick();
    rst = 1'b0;
    tick();
    total++;
    if ({bus.mul_a, bus.mul_b, bus.mul_st, bus.resp_valid} !== 18'b0) begin
      bad++;
      $display("FAIL midrst_clear: a=%h b=%h st=%b valid=%b, want 0", bus.mul_a, bus.mul_b,
               bus.mul_st, bus.resp_valid);
    end
    tick();
    rst    = 1'b1;
    vcount = 0;
    for (int n = 0; n < 15; n++) begin
      tick();
      if (bus.resp_valid === 1'b1 || bus.gnt !== '0) vcount++;
    end
    total++;
    if (vcount != 0) begin
      bad++;
      $display("FAIL midrst_no_resp: got %0d strobe cycles want 0", vcount);
    end
    set_ops(0, 8'h03, 8'h04);
    bus.req = 4'b1111;
    wait_gnt(g, at);
    bus.req = '0;
    total++;
    if (g !== 4'b0001) begin
      bad++;
      $display("FAIL midrst_ptr: got %b want 0001", g);
    end
    wait_resp(seen, d, id, e, at);
    total++;
    if (!seen || d !== 16'h000C || id !== 3'd0) begin
      bad++;
      $display("FAIL midrst_resp: seen=%0d data=%h id=%0d, want 1 000c 0", seen, d, id);
    end
  endtask

`ifdef MUL_CHECK_EN
  task automatic test_check_err();
    for (int n = 0; n < 2; n++) begin
      core_bias = (n == 0) ? 16'h0001 : 16'h0000;
      set_ops(0, 8'h12, 8'h13);
      bus.req = 4'b0001;
      wait_gnt(g, at);
      bus.req = '0;
      wait_resp(seen, d, id, e, at);
      total++;
      if (!seen || e !== (n == 0) || d !== ((n == 0) ? 16'h0157 : 16'h0156)) begin
        bad++;
        $display("FAIL check_err[%0d]: seen=%0d err=%b data=%h, want 1 %0d %h", n, seen, e, d,
                 (n == 0), (n == 0) ? 16'h0157 : 16'h0156);
      end
    end
  endtask
`endif

  initial begin
    rst       = 1'b0;
    bus.req   = '0;
    bus.req_a = '0;
    bus.req_b = '0;
    test_reset();
    test_single();
    test_round_robin();
    test_wrap_skip();
    test_edge_values();
    test_reset_mid_op();
`ifdef MUL_CHECK_EN
    test_check_err();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/mul8x8_rr_arbiter.md
Name: mul8x8_rr_arbiter

Overview:
- Shares one sequential 8x8 multiplier core (st/a/b in, 16-bit answer out, fixed latency, no done flag) between NREQ requesters.
- Round-robin arbitration; the winner's operands are latched and held on the core for the whole operation.
- Drives the core start pulse and counts the core's fixed latency.
- Returns the product tagged with the requester ID.

Parameters:
- NREQ, 4, number of requesters (2..8).
- MUL_LAT, 10, clock edges from first mul_st-high edge until mul_answer is valid (>=2).
- ST_CYC, 1, number of cycles mul_st is held high per operation (1..MUL_LAT-1).

Ports:
- clk  in  1  single system clock, rising edge.
- rst  in  1  synchronous, active-low reset (sampled on clk rising edge; 0 = reset).
- req  in  NREQ  per-requester request level; operands must be stable while high.
- req_a  in  8*NREQ  operand A, requester i at bits [8i+7:8i].
- req_b  in  8*NREQ  operand B, same packing.
- gnt  out  NREQ  one-hot acceptance pulse, one cycle.
- resp_valid  out  1  one-cycle result strobe.
- resp_id  out  3  index of the requester owning resp_data.
- resp_data  out  16  product a*b, unsigned.
- mul_st  out  1  start to the multiplier core.
- mul_a  out  8  operand A to the core.
- mul_b  out  8  operand B to the core.
- mul_answer  in  16  core product.

Behaviour:
- Reset (rst=0 at an edge):
  - gnt=0, resp_valid=0, resp_id=0, resp_data=0.
  - mul_st=0, mul_a=0, mul_b=0.
  - Round-robin pointer=0, state=IDLE, counter=0.
  - Reset mid-operation aborts it: no resp_valid and no gnt is ever issued for it.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - If req!=0 at edge E0: select the first set bit searching upward from the pointer, wrapping at NREQ-1 to 0.
  - At E0: gnt[i]<=1, mul_a/mul_b<=req_a/req_b slice i, mul_st<=1, id register<=i, counter<=0.
  - Also at E0: pointer<=(i+1) mod NREQ, state<=RUN.
  - If req==0, stay in IDLE; all outputs are held except gnt, which is 0.
- RUN:
  - gnt returns to 0 after one cycle.
  - The counter increments each edge.
  - mul_st is high for exactly ST_CYC cycles starting at E0, then low.
  - mul_a/mul_b stay stable until the next grant.
  - req is ignored in RUN and DONE; no grant is issued.
- End of RUN:
  - At edge E0+MUL_LAT (counter==MUL_LAT-1): resp_data<=mul_answer, resp_id<=id, resp_valid<=1, state<=DONE.
- DONE: resp_valid drops after one cycle; state<=IDLE.
  - resp_data/resp_id hold their values until the next result.
- Throughput: one operation per MUL_LAT+2 cycles. Earliest next gnt is at edge E0+MUL_LAT+2.
- Handshake:
  - Requester keeps req high with stable operands until it sees gnt[i].
  - It deasserts or updates operands in the cycle after gnt.
  - Dropping req before grant is legal and cancels the request silently.
- No backpressure: the consumer must take resp_valid when it is presented.
- Simultaneous requests: exactly one is granted, by pointer order. A permanently asserted set of requests is served cyclically with no starvation.
- A single continuous requester is re-granted every MUL_LAT+2 cycles.
- Arithmetic: unsigned 8x8 -> 16, no truncation. resp_data is exactly mul_answer, never recomputed (unless the check feature below is enabled).

Optional Feature:
- Macro MUL_CHECK_EN.
- Defined:
  - Adds output resp_err (1 bit, reset 0).
  - At capture, an internal product mul_a*mul_b is compared to mul_answer.
  - resp_err is asserted together with resp_valid on mismatch and is 0 otherwise.
- Undefined: no resp_err port and no internal multiplier; behaviour is otherwise identical.

Test Plan:
- Reset sequence:
  - Stimulus: rst=0 for 3 cycles with req=4'b1111.
  - Required response: gnt=0, mul_st=0, resp_valid=0 throughout.
  - After release: first gnt=4'b0001.
- Single op:
  - Stimulus: req[0], a=8'h12, b=8'h13.
  - Required response: gnt[0] at E0; mul_st high 1 cycle; resp_valid at E0+10 with resp_data=16'h0156, resp_id=0.
- Round-robin:
  - Stimulus: req=4'b1111 held, operands i+1 by 8'h12 for requester i.
  - Required response: grant order 0,1,2,3,0; results 16'h0012, 16'h0024, 16'h0036, 16'h0048; gnt spacing 12 cycles.
- Pointer wrap/skip:
  - Stimulus: grant 3, then req=4'b1010.
  - Required response: next grant=1, then 3.
- Edge values:
  - Stimulus: a=8'hFF, b=8'hFF, then 8'h23*8'h12, then 8'h00*8'h7F.
  - Required response: results 16'hFE01, 16'h0276, 16'h0000.
- Reset mid-op:
  - Stimulus: rst=0 at E0+5.
  - Required response: no resp_valid; pointer restarts at 0; mul_a/mul_b=0.
  - With MUL_CHECK_EN and a core model forced wrong by 1: resp_err=1 with resp_valid.
